// File: rtl/bnn_fc_argmax_if.sv
// Stream/result bundle for bnn_fc_argmax: activation beats in, argmax result out.
// The master drives beats; the slave (the layer) returns status and the winning class.
interface bnn_fc_argmax_if #(
    parameter int N_CLASSES = 10,
    parameter int ACC_W     = 8,
    parameter int CLS_W     = $clog2(N_CLASSES)
);
    logic                    start;
    logic                    ivalid;
    logic                    din;
    logic [N_CLASSES-1:0]    weight;
    logic                    busy;
    logic                    done;
    logic [CLS_W-1:0]        class_idx;
    logic signed [ACC_W-1:0] max_score;
    logic                    drop;

    modport master (
        output start, ivalid, din, weight,
        input  busy, done, class_idx, max_score, drop
    );

    modport slave (
        input  start, ivalid, din, weight,
        output busy, done, class_idx, max_score, drop
    );
endinterface

// File: rtl/bnn_fc_argmax.sv
// Binary fully-connected output layer: XNOR-popcount accumulation over a serial
// activation stream, followed by a sequential argmax scan (ties go to the lowest index).
module bnn_fc_argmax #(
    parameter int N_CLASSES = 10,
    parameter int IN_LEN    = 12,
    parameter int ACC_W     = 8,
    parameter int CLS_W     = $clog2(N_CLASSES)
) (
    input  logic          clk,
    input  logic          rstn,
    bnn_fc_argmax_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_ARGMAX = 2'd2;

    localparam int CNT_W = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam logic [CNT_W-1:0]        LAST_BEAT = CNT_W'(IN_LEN - 1);
    localparam logic [CLS_W-1:0]        LAST_CLS  = CLS_W'(N_CLASSES - 1);
    localparam logic signed [ACC_W-1:0] STEP_UP   = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] STEP_DN   = '1;

    logic [1:0]              state;
    logic [CNT_W-1:0]        beat_cnt;
    logic [CLS_W-1:0]        scan_idx;
    logic [CLS_W-1:0]        best_idx;
    logic signed [ACC_W-1:0] best_val;
    logic [CLS_W-1:0]        class_idx_q;
    logic signed [ACC_W-1:0] max_score_q;
    logic                    done_q;
    logic                    drop_q;
    logic signed [ACC_W-1:0] acc [N_CLASSES];

    logic                    accept;
    logic signed [ACC_W-1:0] cand_val;
    logic signed [ACC_W-1:0] next_val;
    logic [CLS_W-1:0]        next_idx;

    // start outranks everything, so a beat arriving with it is never accumulated
    assign accept = (state == ST_ACCUM) && bus.ivalid && !bus.start;

    always_comb begin
        cand_val = acc[scan_idx];
        next_val = best_val;
        next_idx = best_idx;
        if ((scan_idx == '0) || (cand_val > best_val)) begin
            next_val = cand_val;
            next_idx = scan_idx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < N_CLASSES; k++) acc[k] <= '0;
        end else if (bus.start) begin
            for (int unsigned k = 0; k < N_CLASSES; k++) acc[k] <= '0;
        end else if (accept) begin
            for (int unsigned k = 0; k < N_CLASSES; k++)
                acc[k] <= acc[k] + ((bus.din ~^ bus.weight[k]) ? STEP_UP : STEP_DN);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            beat_cnt    <= '0;
            scan_idx    <= '0;
            best_idx    <= '0;
            best_val    <= '0;
            class_idx_q <= '0;
            max_score_q <= '0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            drop_q <= bus.ivalid && !accept;
            if (bus.start) begin
                state       <= ST_ACCUM;
                beat_cnt    <= '0;
                scan_idx    <= '0;
                best_idx    <= '0;
                best_val    <= '0;
                class_idx_q <= '0;
                max_score_q <= '0;
            end else begin
                case (state)
                    ST_ACCUM: begin
                        if (accept) begin
                            if (beat_cnt == LAST_BEAT) begin
                                beat_cnt <= '0;
                                scan_idx <= '0;
                                state    <= ST_ARGMAX;
                            end else begin
                                beat_cnt <= beat_cnt + 1'b1;
                            end
                        end
                    end
                    ST_ARGMAX: begin
                        best_val <= next_val;
                        best_idx <= next_idx;
                        if (scan_idx == LAST_CLS) begin
                            class_idx_q <= next_idx;
                            max_score_q <= next_val;
                            done_q      <= 1'b1;
                            scan_idx    <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            scan_idx <= scan_idx + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.drop      = drop_q;
    assign bus.class_idx = class_idx_q;
    assign bus.max_score = max_score_q;
endmodule

// File: tb/tb_bnn_fc_argmax.sv
// Directed bench for bnn_fc_argmax: default 10x12 layer plus a 4-class, 64-bit frame instance.
module tb_bnn_fc_argmax;
    logic clk = 1'b0;
    logic rstn;
    int   tests = 0;
    int   fails = 0;
    int   done_seen0 = 0;
    int   drop_seen0 = 0;
    int   n;

    logic [11:0] pat   = 12'b1011_0010_1110;
    logic [63:0] pat64 = 64'hC3A5_0F96_7E21_B84D;

    always #5 clk = ~clk;

    bnn_fc_argmax_if #(.N_CLASSES(10), .ACC_W(8), .CLS_W(4)) bus0 ();
    bnn_fc_argmax_if #(.N_CLASSES(4),  .ACC_W(8), .CLS_W(2)) bus1 ();

    bnn_fc_argmax #(.N_CLASSES(10), .IN_LEN(12), .ACC_W(8), .CLS_W(4)) dut (
        .clk(clk), .rstn(rstn), .bus(bus0)
    );
    bnn_fc_argmax #(.N_CLASSES(4), .IN_LEN(64), .ACC_W(8), .CLS_W(2)) dut_s (
        .clk(clk), .rstn(rstn), .bus(bus1)
    );

    always @(negedge clk) begin
        if (bus0.done === 1'b1) done_seen0++;
        if (bus0.drop === 1'b1) drop_seen0++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start0;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
    endtask

    task automatic beat0(input logic d, input logic [9:0] w);
        bus0.ivalid = 1'b1;
        bus0.din    = d;
        bus0.weight = w;
        tick();
        bus0.ivalid = 1'b0;
    endtask

    function automatic logic [9:0] hot_w(input logic d, input int cls);
        logic [9:0] w;
        w = 10'b1 << cls;
        return d ? w : ~w;
    endfunction

    task automatic wait_done0(output int cnt);
        cnt = 0;
        while (bus0.done !== 1'b1 && cnt < 60) begin
            tick();
            cnt++;
        end
    endtask

    task automatic frame0(input int cls);
        start0();
        for (int j = 0; j < 12; j++) beat0(pat[j], hot_w(pat[j], cls));
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        bus0.start = 0; bus0.ivalid = 0; bus0.din = 0; bus0.weight = '0;
        bus1.start = 0; bus1.ivalid = 0; bus1.din = 0; bus1.weight = '0;
        repeat (2) tick();
        tests++;
        if ({bus0.busy, bus0.done, bus0.drop, bus0.class_idx, bus0.max_score} !== 15'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {bus0.busy, bus0.done, bus0.drop, bus0.class_idx, bus0.max_score});
        end
        tests++;
        if ({bus1.busy, bus1.done, bus1.drop, bus1.class_idx, bus1.max_score} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs_small: got %h expected 0",
                     {bus1.busy, bus1.done, bus1.drop, bus1.class_idx, bus1.max_score});
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single_winner;
        int d0, p0;
        d0 = done_seen0;
        p0 = drop_seen0;
        frame0(3);
        tests++;
        if (bus0.busy !== 1'b1) begin
            fails++; $display("FAIL single_busy_scan: got %b expected 1", bus0.busy);
        end
        wait_done0(n);
        tests++;
        if (n != 10) begin fails++; $display("FAIL single_latency: got %0d expected 10", n); end
        tests++;
        if (bus0.class_idx !== 4'd3) begin
            fails++; $display("FAIL single_class: got %0d expected 3", bus0.class_idx);
        end
        tests++;
        if (bus0.max_score !== 8'sd12) begin
            fails++; $display("FAIL single_score: got %0d expected 12", bus0.max_score);
        end
        tick();
        tests++;
        if (bus0.done !== 1'b0 || bus0.busy !== 1'b0) begin
            fails++; $display("FAIL single_done_pulse: got done=%b busy=%b expected 0 0", bus0.done, bus0.busy);
        end
        tests++;
        if (bus0.class_idx !== 4'd3) begin
            fails++; $display("FAIL single_hold: got %0d expected 3", bus0.class_idx);
        end
        tests++;
        if (done_seen0 - d0 != 1 || drop_seen0 - p0 != 0) begin
            fails++; $display("FAIL single_counts: got done=%0d drop=%0d expected 1 0", done_seen0 - d0, drop_seen0 - p0);
        end
    endtask

    task automatic test_tie;
        logic [9:0] w;
        start0();
        for (int j = 0; j < 12; j++) begin
            w = '0;
            if (j < 10) w = w | 10'b0010000100;
            if (j < 4)  w = w | 10'b1101111011;
            beat0(pat[j], pat[j] ? w : ~w);
        end
        wait_done0(n);
        tests++;
        if (n != 10) begin fails++; $display("FAIL tie_latency: got %0d expected 10", n); end
        tests++;
        if (bus0.class_idx !== 4'd2) begin
            fails++; $display("FAIL tie_class: got %0d expected 2", bus0.class_idx);
        end
        tests++;
        if (bus0.max_score !== 8'sd8) begin
            fails++; $display("FAIL tie_score: got %0d expected 8", bus0.max_score);
        end
        tick();
    endtask

    task automatic test_bubbles;
        int d0;
        d0 = done_seen0;
        start0();
        for (int j = 0; j < 12; j++) begin
            repeat (j % 3) tick();
            beat0(pat[j], hot_w(pat[j], 3));
            if (j == 10) begin
                tests++;
                if (bus0.busy !== 1'b1 || done_seen0 != d0) begin
                    fails++; $display("FAIL bubble_early_end: got busy=%b done_count=%0d expected 1 %0d", bus0.busy, done_seen0, d0);
                end
            end
        end
        wait_done0(n);
        tests++;
        if (n != 10) begin fails++; $display("FAIL bubble_latency: got %0d expected 10", n); end
        tests++;
        if (bus0.class_idx !== 4'd3 || bus0.max_score !== 8'sd12) begin
            fails++; $display("FAIL bubble_result: got %0d/%0d expected 3/12", bus0.class_idx, bus0.max_score);
        end
        tick();
    endtask

    task automatic test_abort;
        int d0;
        d0 = done_seen0;
        start0();
        for (int j = 0; j < 5; j++) beat0(pat[j], hot_w(pat[j], 4));
        // restart with a beat that would penalise every class if it were accepted
        bus0.start  = 1'b1;
        bus0.ivalid = 1'b1;
        bus0.din    = 1'b1;
        bus0.weight = '0;
        tick();
        bus0.start  = 1'b0;
        bus0.ivalid = 1'b0;
        tests++;
        if (bus0.drop !== 1'b1) begin fails++; $display("FAIL abort_drop: got %b expected 1", bus0.drop); end
        for (int j = 0; j < 12; j++) beat0(pat[j], hot_w(pat[j], 9));
        wait_done0(n);
        tests++;
        if (n != 10) begin fails++; $display("FAIL abort_latency: got %0d expected 10", n); end
        tests++;
        if (bus0.class_idx !== 4'd9 || bus0.max_score !== 8'sd12) begin
            fails++; $display("FAIL abort_result: got %0d/%0d expected 9/12", bus0.class_idx, bus0.max_score);
        end
        tick();
        tests++;
        if (done_seen0 - d0 != 1) begin
            fails++; $display("FAIL abort_done_count: got %0d expected 1", done_seen0 - d0);
        end
    endtask

    task automatic test_reset_mid_scan;
        int d0;
        frame0(6);
        repeat (3) tick();
        d0 = done_seen0;
        tests++;
        if (bus0.busy !== 1'b1) begin fails++; $display("FAIL rst_pre_busy: got %b expected 1", bus0.busy); end
        rstn = 1'b0;
        #1;
        tests++;
        if ({bus0.busy, bus0.done, bus0.drop, bus0.class_idx, bus0.max_score} !== 15'd0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got %h expected 0",
                     {bus0.busy, bus0.done, bus0.drop, bus0.class_idx, bus0.max_score});
        end
        repeat (2) tick();
        rstn = 1'b1;
        repeat (12) tick();
        tests++;
        if (done_seen0 != d0 || bus0.busy !== 1'b0) begin
            fails++; $display("FAIL rst_no_done: got done_count=%0d busy=%b expected %0d 0", done_seen0, bus0.busy, d0);
        end
        frame0(6);
        wait_done0(n);
        tests++;
        if (n != 10 || bus0.class_idx !== 4'd6 || bus0.max_score !== 8'sd12) begin
            fails++; $display("FAIL rst_recover: got lat=%0d %0d/%0d expected 10 6/12", n, bus0.class_idx, bus0.max_score);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        frame0(1);
        wait_done0(n);
        tests++;
        if (n != 10 || bus0.class_idx !== 4'd1) begin
            fails++; $display("FAIL b2b_first: got lat=%0d class=%0d expected 10 1", n, bus0.class_idx);
        end
        start0();
        tests++;
        if (bus0.done !== 1'b0 || bus0.busy !== 1'b1 || bus0.class_idx !== 4'd0 || bus0.max_score !== 8'sd0) begin
            fails++; $display("FAIL b2b_restart: got done=%b busy=%b %0d/%0d expected 0 1 0/0",
                              bus0.done, bus0.busy, bus0.class_idx, bus0.max_score);
        end
        for (int j = 0; j < 12; j++) beat0(pat[j], hot_w(pat[j], 8));
        wait_done0(n);
        tests++;
        if (n != 10 || bus0.class_idx !== 4'd8 || bus0.max_score !== 8'sd12) begin
            fails++; $display("FAIL b2b_second: got lat=%0d %0d/%0d expected 10 8/12", n, bus0.class_idx, bus0.max_score);
        end
        tick();
    endtask

    task automatic test_all_negative_drop;
        int p0;
        p0 = drop_seen0;
        start0();
        for (int j = 0; j < 12; j++) beat0(pat[j], pat[j] ? 10'h000 : 10'h3FF);
        tick();
        beat0(1'b1, 10'h3FF);
        tests++;
        if (bus0.drop !== 1'b1) begin fails++; $display("FAIL neg_drop_high: got %b expected 1", bus0.drop); end
        tick();
        tests++;
        if (bus0.drop !== 1'b0) begin fails++; $display("FAIL neg_drop_low: got %b expected 0", bus0.drop); end
        wait_done0(n);
        tests++;
        if (n != 7) begin fails++; $display("FAIL neg_latency: got %0d expected 7", n); end
        tests++;
        if (bus0.class_idx !== 4'd0 || bus0.max_score !== -8'sd12) begin
            fails++; $display("FAIL neg_result: got %0d/%0d expected 0/-12", bus0.class_idx, bus0.max_score);
        end
        tests++;
        if (drop_seen0 - p0 != 1) begin
            fails++; $display("FAIL neg_drop_count: got %0d expected 1", drop_seen0 - p0);
        end
        tick();
    endtask

    task automatic test_small_config;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int j = 0; j < 64; j++) begin
            bus1.ivalid = 1'b1;
            bus1.din    = pat64[j];
            bus1.weight = pat64[j] ? 4'b0010 : 4'b1101;
            tick();
        end
        bus1.ivalid = 1'b0;
        n = 0;
        while (bus1.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (n != 4) begin fails++; $display("FAIL small_latency: got %0d expected 4", n); end
        tests++;
        if (bus1.class_idx !== 2'd1 || bus1.max_score !== 8'sd64) begin
            fails++; $display("FAIL small_result: got %0d/%0d expected 1/64", bus1.class_idx, bus1.max_score);
        end
        tick();
        tests++;
        if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin
            fails++; $display("FAIL small_done_pulse: got done=%b busy=%b expected 0 0", bus1.done, bus1.busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_winner();
        test_tie();
        test_bubbles();
        test_abort();
        test_reset_mid_scan();
        test_back_to_back();
        test_all_negative_drop();
        test_small_config();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bnn_fc_argmax.md
# bnn_fc_argmax

Parametrised binary fully-connected output layer with built-in argmax. It sits after the maxpool stage and replaces the fixed array of 12-input FC units, the per-unit result buses and the external one-hot/encoder path. It accepts a serial stream of binarised activations together with one weight bit per class per cycle. It accumulates XNOR-popcount scores for `N_CLASSES` neurons, then scans them sequentially and reports the winning class index and its score.

## Interface
Parameters:
- `N_CLASSES`, default 10: number of output neurons. Must be at least 2.
- `IN_LEN`, default 12: activation bits per frame. Must be at least 1.
- `ACC_W`, default 8: signed accumulator width. Must be at least clog2(IN_LEN+1)+1.
- `CLS_W`, default clog2(N_CLASSES): width of the class index.

Ports:
- `clk` in 1: clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: begin a new frame. Clears all accumulators.
- `ivalid` in 1: `din` and `weight` are valid this cycle.
- `din` in 1: activation bit. 1 means +1, 0 means -1.
- `weight` in N_CLASSES: bit k is the weight of neuron k for the current activation.
- `busy` out 1: high in ACCUM and ARGMAX.
- `done` out 1: one-cycle pulse when the result is valid.
- `class_idx` out CLS_W: winning neuron index. Held until the next `start`.
- `max_score` out ACC_W, signed: score of the winning neuron. Held until the next `start`.
- `drop` out 1: one-cycle pulse when an `ivalid` beat is discarded.

## Operation
The block has three states: IDLE, ACCUM and ARGMAX. All registers reset to 0 and the state resets to IDLE. `done`, `drop` and `busy` reset to 0.

Accumulation:
- Each neuron has a signed accumulator `acc[k]` of ACC_W bits.
- On an accepted beat, `acc[k] += (din XNOR weight[k]) ? +1 : -1`.
- Scores stay in the range [-IN_LEN, +IN_LEN], so the accumulators never overflow.

State transitions:
- IDLE, `start`=1 → ACCUM.
  - Clear every `acc[k]` and the beat counter.
  - Clear `class_idx` and `max_score`.
  - An `ivalid` asserted in the same cycle as `start` is discarded and `drop` pulses.
- ACCUM, `ivalid`=1 → the beat is accepted and the counter increments.
  - When the beat counter reaches IN_LEN-1 on an accepted beat, go to ARGMAX on the next edge.
  - Bubbles (`ivalid`=0) are allowed anywhere in the frame.
- ACCUM or ARGMAX, `start`=1 → abort and restart.
  - Behaves exactly like `start` in IDLE: accumulators cleared, next state ACCUM, no `done`.
  - `start` has priority over every other event in the same cycle.
- ARGMAX: scan index i = 0 .. N_CLASSES-1, one index per cycle.
  - The best-so-far value is initialised to `acc[0]` at i=0.
  - It is replaced only when `acc[i]` is strictly greater, so ties resolve to the lowest index.
  - After i = N_CLASSES-1, register `class_idx` and `max_score`, pulse `done`, and go to IDLE.
- `ivalid` in IDLE without `start`, or in ARGMAX: the beat is discarded, `drop` pulses, and the accumulators are unchanged.

Reset:
- Asserting `rstn` at any time, including mid-frame or mid-scan, immediately returns the block to its reset state.
- A frame interrupted by reset produces no `done`.

## Timing
- Beats are sampled on the rising edge of `clk` when `ivalid` is high in ACCUM.
- Let E0 be the edge that samples the final (IN_LEN-th) beat.
  - `busy` stays high from the edge after `start` through the edge E0+N_CLASSES.
  - ARGMAX occupies the edges E0+1 .. E0+N_CLASSES.
  - `done` is high for exactly one cycle, between edges E0+N_CLASSES and E0+N_CLASSES+1.
  - `class_idx` and `max_score` change at edge E0+N_CLASSES, together with `done`.
- Minimum frame period is IN_LEN + N_CLASSES + 1 cycles, start to start, with no bubbles.
  - `start` may be asserted in the same cycle as `done`; the block re-enters ACCUM at the next edge.
- `drop` is registered: it is high in the cycle after the discarded beat.

## Test plan
1. Defaults, `start`, then 12 back-to-back beats; `weight[3]`=`din` and all other weight bits equal ~`din` → `done` 23 cycles after `start` (12 beats, 10 scan cycles, 1), `class_idx`=3, `max_score`=+12.
2. Tie: neurons 2 and 7 each match 10 of 12 bits, all others match 4 → `class_idx`=2, `max_score`=+8.
3. Same stimulus as test 1 with random `ivalid` bubbles → same result, with `done` exactly N_CLASSES cycles after the edge that samples the last beat.
4. `start` after 5 accepted beats, then a full frame targeting class 9 → no `done` for the aborted frame; result is `class_idx`=9, `max_score`=+12.
5. `rstn` low during ARGMAX → all outputs 0, no `done`, state IDLE; a subsequent frame completes normally.
6. All weights equal ~`din`, plus `ivalid` pulsed during ARGMAX → `class_idx`=0, `max_score`=-12, one `drop` pulse, score unaffected; also run with N_CLASSES=4 and IN_LEN=64 and check the same scan-then-`done` latency.
